// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants and the CDB broadcast record.
// Contents: default tag/data widths, reserved station tags, the idle data
// value driven on the CDB, and the cdb_bus_t {valid, tag, data} record.
package tomasulo_pkg;

  localparam int unsigned CDB_TAG_W  = 3;
  localparam int unsigned CDB_DATA_W = 16;

  // Tag 0 means "no producer"; the ADD stations occupy tags 1 and 2.
  localparam logic [CDB_TAG_W-1:0] TAG_FREE = 3'd0;
  localparam logic [CDB_TAG_W-1:0] TAG_ADD1 = 3'd1;
  localparam logic [CDB_TAG_W-1:0] TAG_ADD2 = 3'd2;

  localparam logic [CDB_DATA_W-1:0] DATA_NONE = 16'hFFF0;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result/CDB bundle between the ADD result sources and cdb_arbiter.
// master: result producer side (drives Req/Tag_In/Data_In, sees Ack, CDB, Pending)
// slave : the arbiter itself
interface cdb_arbiter_if
  import tomasulo_pkg::*;
#(
  parameter int unsigned N_SRC  = 2,
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned DATA_W = CDB_DATA_W
);
  logic [N_SRC-1:0]        Req;
  logic [N_SRC*TAG_W-1:0]  Tag_In;
  logic [N_SRC*DATA_W-1:0] Data_In;
  logic [N_SRC-1:0]        Ack;
  logic                    CDB_Valid;
  logic [TAG_W-1:0]        CDB_Tag;
  logic [DATA_W-1:0]       CDB_Data;
  logic [N_SRC-1:0]        Pending;

  modport master (
    output Req, Tag_In, Data_In,
    input  Ack, CDB_Valid, CDB_Tag, CDB_Data, Pending
  );

  modport slave (
    input  Req, Tag_In, Data_In,
    output Ack, CDB_Valid, CDB_Tag, CDB_Data, Pending
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req   - candidate vector
//        last  - index of the most recent winner; search starts at last+1
//        grant - one-hot winner, or zero when no candidate
module rr_arbiter #(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned LW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [LW-1:0]    last,
  output logic [N_SRC-1:0] grant
);

  logic [LW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      idx = LW'((32'(last) + k) % N_SRC);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Tomasulo write-back stage: buffers one tagged result per source and
// broadcasts one per cycle on the Common Data Bus, round-robin.
// Ports: Clock (rising edge), Reset (async, active-high), Flush (sync clear),
//        bus (cdb_arbiter_if.slave): Req/Tag_In/Data_In in, Ack out
//        (combinational), CDB_Valid/CDB_Tag/CDB_Data out (registered),
//        Pending out (slot-full flags).
// Build option: define CDB_BYPASS_EN to broadcast straight from the inputs
// at the accepting edge when every slot is empty (1-edge latency).
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int unsigned N_SRC  = 2,
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned DATA_W = CDB_DATA_W
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Flush,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned LW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]  full_q, full_d;
  logic [TAG_W-1:0]  tag_q  [N_SRC];
  logic [TAG_W-1:0]  tag_d  [N_SRC];
  logic [DATA_W-1:0] data_q [N_SRC];
  logic [DATA_W-1:0] data_d [N_SRC];
  logic [LW-1:0]     last_q, last_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

  logic [TAG_W-1:0]  tag_in  [N_SRC];
  logic [DATA_W-1:0] data_in [N_SRC];
  logic [N_SRC-1:0]  tag_nz, grant, ack, store;
  logic [LW-1:0]     g;

  function automatic logic [LW-1:0] onehot_idx(input logic [N_SRC-1:0] oh);
    logic [LW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (oh[i]) r = LW'(i);
    end
    return r;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      tag_in[i]  = bus.Tag_In[i*TAG_W +: TAG_W];
      data_in[i] = bus.Data_In[i*DATA_W +: DATA_W];
      tag_nz[i]  = (tag_in[i] != TAG_W'(TAG_FREE));
    end
  end

  rr_arbiter #(.N_SRC(N_SRC)) u_rr (
    .req   (full_q),
    .last  (last_q),
    .grant (grant)
  );

  // A granted slot empties this edge, so it may accept a new result now.
  always_comb ack = {N_SRC{!Flush}} & (~full_q | grant);

`ifdef CDB_BYPASS_EN
  logic [N_SRC-1:0] byp_req, byp_grant;

  always_comb byp_req = ((full_q == '0) && !Flush) ? (bus.Req & tag_nz) : '0;

  rr_arbiter #(.N_SRC(N_SRC)) u_rr_byp (
    .req   (byp_req),
    .last  (last_q),
    .grant (byp_grant)
  );

  // The bypass winner goes straight to the CDB and is not buffered.
  always_comb store = bus.Req & ack & tag_nz & ~byp_grant;
`else
  always_comb store = bus.Req & ack & tag_nz;
`endif

  always_comb begin
    full_d      = full_q;
    tag_d       = tag_q;
    data_d      = data_q;
    last_d      = last_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = '0;
    cdb_data_d  = DATA_W'(DATA_NONE);
    g           = '0;
    if (Flush) begin
      full_d = '0;
    end else begin
      if (|grant) begin
        g           = onehot_idx(grant);
        cdb_valid_d = 1'b1;
        cdb_tag_d   = tag_q[g];
        cdb_data_d  = data_q[g];
        last_d      = g;
        full_d[g]   = 1'b0;
      end
`ifdef CDB_BYPASS_EN
      if (|byp_grant) begin
        g           = onehot_idx(byp_grant);
        cdb_valid_d = 1'b1;
        cdb_tag_d   = tag_in[g];
        cdb_data_d  = data_in[g];
        last_d      = g;
      end
`endif
      // Tag-0 results are acked but never stored, so they vanish here.
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (store[i]) begin
          full_d[i] = 1'b1;
          tag_d[i]  = tag_in[i];
          data_d[i] = data_in[i];
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      full_q <= '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= DATA_W'(DATA_NONE);
      end
      last_q      <= LW'(N_SRC - 1);
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= DATA_W'(DATA_NONE);
    end else begin
      full_q      <= full_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      last_q      <= last_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  assign bus.Ack       = ack;
  assign bus.Pending   = full_q;
  assign bus.CDB_Valid = cdb_valid_q;
  assign bus.CDB_Tag   = cdb_tag_q;
  assign bus.CDB_Data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected broadcasts,
// a negedge monitor pops and compares every CDB cycle.
module tb_cdb_arbiter;
  import tomasulo_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  cdb_arbiter_if #(.N_SRC(2), .TAG_W(CDB_TAG_W), .DATA_W(CDB_DATA_W)) bus_if ();

  cdb_arbiter #(.N_SRC(2), .TAG_W(CDB_TAG_W), .DATA_W(CDB_DATA_W)) dut (
    .Clock (clk),
    .Reset (rst),
    .Flush (flush),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  cdb_bus_t    exp_q[$];
  cdb_bus_t    mon_e;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_bc(input logic [2:0] t, input logic [15:0] d);
    exp_q.push_back(cdb_bus_t'{valid: 1'b1, tag: t, data: d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] r, input logic [2:0] t0, input logic [15:0] d0,
                         input logic [2:0] t1, input logic [15:0] d1);
    bus_if.Req     = r;
    bus_if.Tag_In  = {t1, t0};
    bus_if.Data_In = {d1, d0};
  endtask

  task automatic do_reset();
    chk("drained_before_reset", exp_q.size(), 0);
    flush = 1'b0;
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Monitor: every cycle out of reset, the CDB is either the next expected
  // broadcast or exactly idle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.CDB_Valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_broadcast", 32'(bus_if.CDB_Valid), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bc_tag", 32'(bus_if.CDB_Tag), 32'(mon_e.tag));
          chk("bc_data", 32'(bus_if.CDB_Data), 32'(mon_e.data));
        end
      end else begin
        chk("idle_tag", 32'(bus_if.CDB_Tag), 0);
        chk("idle_data", 32'(bus_if.CDB_Data), 32'h0000FFF0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  int unsigned idx0, idx1;
  logic [1:0]  a, r;

  initial begin
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    #1 rst = 1'b1;
    #1;
    chk("rst_pending", 32'(bus_if.Pending), 0);
    chk("rst_valid", 32'(bus_if.CDB_Valid), 0);
    chk("rst_tag", 32'(bus_if.CDB_Tag), 0);
    chk("rst_data", 32'(bus_if.CDB_Data), 32'h0000FFF0);
    tick();
    tick();
    rst = 1'b0;
    #1;

`ifdef CDB_BYPASS_EN
    // Idle arbiter: winner goes out right after the accepting edge.
    set_req(2'b10, 3'd0, 16'h0, 3'd2, 16'h00AB);
    expect_bc(3'd2, 16'h00AB);
    #1 chk("byp_ack", 32'(bus_if.Ack), 2'b11);
    tick();
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    #1;
    chk("byp_valid", 32'(bus_if.CDB_Valid), 1);
    chk("byp_tag", 32'(bus_if.CDB_Tag), 2);
    chk("byp_data", 32'(bus_if.CDB_Data), 16'h00AB);
    chk("byp_pending", 32'(bus_if.Pending), 0);
    tick();
    // Two requesters: Last=1 so source 0 bypasses, source 1 is buffered.
    set_req(2'b11, 3'd1, 16'h0011, 3'd2, 16'h0022);
    expect_bc(3'd1, 16'h0011);
    expect_bc(3'd2, 16'h0022);
    tick();
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    #1 chk("byp2_pending", 32'(bus_if.Pending), 2'b10);
    tick();
    #1 chk("byp2_pending_drained", 32'(bus_if.Pending), 0);
    tick();
    tick();
`else
    // Single result: accepted at edge k, on the CDB for one cycle after k+1.
    set_req(2'b01, 3'd1, 16'h0005, 3'd0, 16'h0);
    expect_bc(3'd1, 16'h0005);
    #1 chk("t1_ack", 32'(bus_if.Ack), 2'b11);
    tick();
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    #1 chk("t1_pending_k", 32'(bus_if.Pending), 2'b01);
    chk("t1_not_yet_valid", 32'(bus_if.CDB_Valid), 0);
    tick();
    #1 chk("t1_pending_k1", 32'(bus_if.Pending), 0);
    tick();
    tick();

    // Simultaneous requests: source 0 first, then source 1.
    do_reset();
    set_req(2'b11, 3'd1, 16'h0011, 3'd2, 16'h0022);
    expect_bc(3'd1, 16'h0011);
    expect_bc(3'd2, 16'h0022);
    #1 chk("t2_ack", 32'(bus_if.Ack), 2'b11);
    tick();
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    #1 chk("t2_pending_11", 32'(bus_if.Pending), 2'b11);
    tick();
    #1 chk("t2_pending_10", 32'(bus_if.Pending), 2'b10);
    tick();
    #1 chk("t2_pending_00", 32'(bus_if.Pending), 0);
    tick();
    tick();

    // Both sources stream 4 results each, holding until acked.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      expect_bc(3'd1, 16'(16'h0100 + n));
      expect_bc(3'd2, 16'(16'h0200 + n));
    end
    idx0 = 0;
    idx1 = 0;
    for (int c = 0; c < 8; c++) begin
      r = {(idx1 < 4) ? 1'b1 : 1'b0, (idx0 < 4) ? 1'b1 : 1'b0};
      set_req(r, 3'd1, 16'(16'h0100 + idx0), 3'd2, 16'(16'h0200 + idx1));
      #1;
      a = bus_if.Ack;
      chk("t3_ack", 32'(a), (c == 0) ? 2'b11 : ((c % 2 == 1) ? 2'b01 : 2'b10));
      tick();
      if (r[0] && a[0]) idx0++;
      if (r[1] && a[1]) idx1++;
    end
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    chk("t3_src0_sent", idx0, 4);
    chk("t3_src1_sent", idx1, 4);
    tick();
    tick();
    tick();

    // Slot 1 full and not granted: Ack[1] low, content held until its grant.
    do_reset();
    set_req(2'b11, 3'd1, 16'h0011, 3'd2, 16'h0022);
    expect_bc(3'd1, 16'h0011);
    expect_bc(3'd2, 16'h0022);
    expect_bc(3'd2, 16'h0033);
    tick();
    set_req(2'b10, 3'd0, 16'h0, 3'd2, 16'h0033);
    #1 chk("t4_ack_blocked", 32'(bus_if.Ack), 2'b01);
    chk("t4_pending", 32'(bus_if.Pending), 2'b11);
    tick();
    #1 chk("t4_ack_granted", 32'(bus_if.Ack), 2'b11);
    tick();
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    tick();
    tick();
    tick();

    // Tag 0 is acked and dropped.
    set_req(2'b01, 3'd0, 16'h0077, 3'd0, 16'h0);
    #1 chk("t5_tag0_ack", 32'(bus_if.Ack), 2'b11);
    tick();
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    #1 chk("t5_tag0_pending", 32'(bus_if.Pending), 0);
    tick();
    tick();

    // Make Last=0, fill both, flush; refill must then favour source 1.
    set_req(2'b01, 3'd1, 16'h0044, 3'd0, 16'h0);
    expect_bc(3'd1, 16'h0044);
    tick();
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    tick();
    tick();
    set_req(2'b11, 3'd1, 16'h0055, 3'd2, 16'h0066);
    tick();
    flush = 1'b1;
    set_req(2'b11, 3'd1, 16'h0057, 3'd2, 16'h0067);
    #1 chk("t5_flush_ack", 32'(bus_if.Ack), 0);
    chk("t5_prefl_pending", 32'(bus_if.Pending), 2'b11);
    tick();
    flush = 1'b0;
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    #1 chk("t5_flush_pending", 32'(bus_if.Pending), 0);
    tick();
    tick();
    set_req(2'b11, 3'd1, 16'h0088, 3'd2, 16'h0099);
    expect_bc(3'd2, 16'h0099);
    expect_bc(3'd1, 16'h0088);
    tick();
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    tick();
    tick();
    tick();

    // Asynchronous reset between edges while a broadcast is on the bus.
    do_reset();
    set_req(2'b11, 3'd1, 16'h00A1, 3'd2, 16'h00A2);
    tick();
    set_req(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    tick();
    #1;
    chk("t6_live_valid", 32'(bus_if.CDB_Valid), 1);
    chk("t6_live_tag", 32'(bus_if.CDB_Tag), 1);
    chk("t6_live_data", 32'(bus_if.CDB_Data), 16'h00A1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(bus_if.CDB_Valid), 0);
    chk("t6_async_tag", 32'(bus_if.CDB_Tag), 0);
    chk("t6_async_data", 32'(bus_if.CDB_Data), 32'h0000FFF0);
    chk("t6_async_pending", 32'(bus_if.Pending), 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
